// File: rtl/tlut_pkg.sv
// Shared types and helpers for the temporal-LUT matrix multiply engine.
package tlut_pkg;

  // Engine control states; IDLE accepts operands, SWEEP walks the
  // unary time axis, DONE presents the result until it is consumed.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } tlut_state_e;

  // Width of one per-cycle partial sum: K masked inputs of iw bits each.
  function automatic int psum_width(input int iw, input int k);
    return iw + $clog2(k);
  endfunction

endpackage

// File: rtl/tlut_adder_tree.sv
// Combinational reduction of K masked A elements into one partial sum.
module tlut_adder_tree
  import tlut_pkg::*;
#(
  parameter int K           = 3,
  parameter int INPUT_WIDTH = 4
) (
  input  logic [K-1:0][INPUT_WIDTH-1:0]             operands,
  output logic [psum_width(INPUT_WIDTH, K)-1:0]     sum
);

  localparam int PW = psum_width(INPUT_WIDTH, K);

  // Sum all operands at full partial-sum width so nothing is truncated.
  always_comb begin
    sum = '0;
    for (int k = 0; k < K; k++) begin
      sum = sum + PW'(operands[k]);
    end
  end

endmodule

// File: rtl/tlut_matmul_engine.sv
// Temporal-LUT matrix multiplier: P = A(MxK) * B(KxN), unsigned.
// Handshake: a side transfers on a rising clk edge when its valid and ready
// are both 1; in_ready is 1 only in IDLE, out_valid is 1 only in DONE, and
// the result stays stable until out_ready is seen in DONE.
module tlut_matmul_engine
  import tlut_pkg::*;
#(
  parameter int M            = 3,
  parameter int K            = 3,
  parameter int N            = 3,
  parameter int INPUT_WIDTH  = 4,
  parameter int WEIGHT_WIDTH = 4,
  parameter int ACC_WIDTH    = 8,
  parameter bit SATURATE     = 1'b1
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  input  logic                                   acc_clear,
  input  logic [M*K-1:0][INPUT_WIDTH-1:0]        input_bin,
  input  logic [K*N-1:0][WEIGHT_WIDTH-1:0]       weight_bin,
  output logic                                   out_valid,
  input  logic                                   out_ready,
  output logic [M*N-1:0][ACC_WIDTH-1:0]          accumulated_mult,
  output logic                                   overflow,
  output tlut_state_e                            dbg_state
);

  localparam int PW = psum_width(INPUT_WIDTH, K);

  tlut_state_e                              state_q, state_d;
  logic [M*K-1:0][INPUT_WIDTH-1:0]          a_q;
  logic [K*N-1:0][WEIGHT_WIDTH-1:0]         b_q;
  logic [WEIGHT_WIDTH-1:0]                  wmax_q, wmax_d, t_q;
  logic [M*N-1:0][ACC_WIDTH-1:0]            acc_q, acc_step;
  logic [M*N-1:0]                           carry_vec;
  logic                                     ovf_q;

  // Largest weight decides how many sweep cycles are needed.
  always_comb begin
    wmax_d = '0;
    for (int i = 0; i < K*N; i++) begin
      if (weight_bin[i] > wmax_d) wmax_d = weight_bin[i];
    end
  end

  for (genvar m = 0; m < M; m++) begin : g_row
    for (genvar n = 0; n < N; n++) begin : g_col
      logic [K-1:0][INPUT_WIDTH-1:0] masked;
      logic [PW-1:0]                 psum;
      logic [ACC_WIDTH:0]            psum_ext, sum_ext;

      // A(m,k) contributes while the time index is below weight B(k,n).
      always_comb begin
        masked = '0;
        for (int k = 0; k < K; k++) begin
          masked[k] = (t_q < b_q[k*N+n]) ? a_q[m*K+k] : '0;
        end
      end

      tlut_adder_tree #(.K(K), .INPUT_WIDTH(INPUT_WIDTH)) u_tree (
        .operands (masked),
        .sum      (psum)
      );

      assign psum_ext = (ACC_WIDTH+1)'(psum);
      assign sum_ext  = {1'b0, acc_q[m*N+n]} + psum_ext;
      assign carry_vec[m*N+n] = sum_ext[ACC_WIDTH];
      assign acc_step[m*N+n]  = (sum_ext[ACC_WIDTH] && SATURATE) ? {ACC_WIDTH{1'b1}}
                                                                 : sum_ext[ACC_WIDTH-1:0];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = (wmax_d == '0) ? DONE : SWEEP;
      end
      SWEEP: begin
        if (t_q == wmax_q - 1'b1) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand latch on accept, accumulation and time step during the sweep.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      wmax_q <= '0;
      t_q    <= '0;
      acc_q  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q    <= input_bin;
            b_q    <= weight_bin;
            wmax_q <= wmax_d;
            t_q    <= '0;
            if (acc_clear) begin
              acc_q <= '0;
              ovf_q <= 1'b0;
            end
          end
        end
        SWEEP: begin
          acc_q <= acc_step;
          if (|carry_vec) ovf_q <= 1'b1;
          t_q   <= t_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign accumulated_mult = acc_q;
  assign overflow         = ovf_q;
  assign dbg_state        = state_q;

endmodule

// File: tb/tb_tlut_matmul_engine.sv
// Directed bench for tlut_matmul_engine with a result scoreboard.
module tb_tlut_matmul_engine;
  import tlut_pkg::*;

  localparam int M = 3, K = 3, N = 3, IW = 4, WW = 4, AW = 8;
  localparam bit SAT = 1'b1;
  localparam int PBITS = M*N*AW;
  localparam int W = PBITS + 1;

  logic clk, rst_n, in_valid, in_ready, acc_clear, out_valid, out_ready, overflow;
  logic [M*K-1:0][IW-1:0] input_bin;
  logic [K*N-1:0][WW-1:0] weight_bin;
  logic [M*N-1:0][AW-1:0] accumulated_mult;
  tlut_state_e            dbg_state;

  tlut_matmul_engine #(
    .M(M), .K(K), .N(N), .INPUT_WIDTH(IW), .WEIGHT_WIDTH(WW),
    .ACC_WIDTH(AW), .SATURATE(SAT)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .acc_clear        (acc_clear),
    .input_bin        (input_bin),
    .weight_bin       (weight_bin),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .accumulated_mult (accumulated_mult),
    .overflow         (overflow),
    .dbg_state        (dbg_state)
  );

  // Clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  logic [W-1:0] exp_q[$];
  int model_acc[M*N];
  bit model_ovf;

  logic [M*K-1:0][IW-1:0] a_v;
  logic [K*N-1:0][WW-1:0] b_v;
  int wexp;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: full product plus prior value, clamped (or wrapped) once at the end.
  task automatic push_expected(input logic [M*K-1:0][IW-1:0] a,
                               input logic [K*N-1:0][WW-1:0] b, input bit clr);
    logic [PBITS-1:0] vec;
    int s;
    if (clr) begin
      foreach (model_acc[i]) model_acc[i] = 0;
      model_ovf = 1'b0;
    end
    vec = '0;
    for (int m = 0; m < M; m++) begin
      for (int n = 0; n < N; n++) begin
        s = model_acc[m*N+n];
        for (int k = 0; k < K; k++) s += int'(a[m*K+k]) * int'(b[k*N+n]);
        if (s > (1 << AW) - 1) begin
          model_ovf = 1'b1;
          s = SAT ? (1 << AW) - 1 : s % (1 << AW);
        end
        model_acc[m*N+n] = s;
        vec[(m*N+n)*AW +: AW] = AW'(s);
      end
    end
    exp_q.push_back({model_ovf, vec});
  endtask

  // Drive one operand set and return the expected sweep length.
  task automatic start_op(input logic [M*K-1:0][IW-1:0] a,
                          input logic [K*N-1:0][WW-1:0] b, input bit clr, output int w);
    int guard;
    w = 0;
    for (int i = 0; i < K*N; i++) if (int'(b[i]) > w) w = int'(b[i]);
    push_expected(a, b, clr);
    input_bin  = a;
    weight_bin = b;
    acc_clear  = clr;
    in_valid   = 1'b1;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(posedge clk); #1; guard++;
    end
    check("accept_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  // Wait for the result, compare against the scoreboard, optionally stall.
  task automatic finish_op(input string tag, input int w, input int hold);
    int cycles;
    logic [W-1:0] exp;
    cycles = 0;
    while (!out_valid && cycles < 40) begin
      @(posedge clk); #1; cycles++;
    end
    check({tag, "_latency"}, cycles, w);
    if (exp_q.size() == 0) begin
      check({tag, "_queue"}, 0, 1);
      exp = '0;
    end else begin
      exp = exp_q.pop_front();
    end
    check({tag, "_p"}, accumulated_mult, exp[PBITS-1:0]);
    check({tag, "_ovf"}, overflow, exp[PBITS]);
    for (int h = 0; h < hold; h++) begin
      in_valid = (h == 3);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check({tag, "_hold_valid"}, out_valid, 1'b1);
      check({tag, "_hold_ready"}, in_ready, 1'b0);
      check({tag, "_hold_p"}, accumulated_mult, exp[PBITS-1:0]);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check({tag, "_ret_idle"}, dbg_state, IDLE);
    check({tag, "_ret_ready"}, in_ready, 1'b1);
    check({tag, "_ret_valid"}, out_valid, 1'b0);
  endtask

  initial begin
    // Reset.
    rst_n = 1'b0; in_valid = 1'b0; acc_clear = 1'b0; out_ready = 1'b1;
    input_bin = '0; weight_bin = '0;
    foreach (model_acc[i]) model_acc[i] = 0;
    model_ovf = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ready", in_ready, 1'b1);
    check("rst_valid", out_valid, 1'b0);
    check("rst_p", accumulated_mult, '0);
    check("rst_ovf", overflow, 1'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic 3x3 with A(i)=i, B(i)=i.
    for (int i = 0; i < 9; i++) begin a_v[i] = IW'(i); b_v[i] = WW'(i); end
    start_op(a_v, b_v, 1'b1, wexp);
    finish_op("basic", wexp, 0);

    // Accumulation across two operations.
    for (int i = 0; i < 9; i++) begin a_v[i] = 4'd4; b_v[i] = 4'd1; end
    start_op(a_v, b_v, 1'b1, wexp);
    finish_op("accum_first", wexp, 0);
    start_op(a_v, b_v, 1'b0, wexp);
    finish_op("accum_second", wexp, 0);

    // Saturation, then clear.
    for (int i = 0; i < 9; i++) begin a_v[i] = 4'd15; b_v[i] = 4'd15; end
    start_op(a_v, b_v, 1'b1, wexp);
    finish_op("saturate", wexp, 0);
    for (int i = 0; i < 9; i++) begin a_v[i] = 4'd1; b_v[i] = 4'd1; end
    start_op(a_v, b_v, 1'b1, wexp);
    finish_op("sat_clear", wexp, 0);

    // All-zero weights skip the sweep.
    for (int i = 0; i < 9; i++) begin a_v[i] = IW'($urandom_range(0, 15)); b_v[i] = '0; end
    start_op(a_v, b_v, 1'b1, wexp);
    finish_op("zero_w", wexp, 0);

    // Backpressure with random operands and an ignored in_valid pulse.
    for (int i = 0; i < 9; i++) begin
      a_v[i] = IW'($urandom_range(0, 15));
      b_v[i] = WW'($urandom_range(0, 6));
    end
    b_v[4] = 4'd7;
    out_ready = 1'b0;
    start_op(a_v, b_v, 1'b1, wexp);
    finish_op("backpressure", wexp, 10);

    // Random accumulate without clear.
    for (int i = 0; i < 9; i++) begin
      a_v[i] = IW'($urandom_range(0, 15));
      b_v[i] = WW'($urandom_range(1, 5));
    end
    start_op(a_v, b_v, 1'b0, wexp);
    finish_op("rand_accum", wexp, 0);

    // Reset during the sweep of the basic case.
    for (int i = 0; i < 9; i++) begin a_v[i] = IW'(i); b_v[i] = WW'(i); end
    start_op(a_v, b_v, 1'b1, wexp);
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    #1;
    check("midrst_valid", out_valid, 1'b0);
    check("midrst_p", accumulated_mult, '0);
    check("midrst_ready", in_ready, 1'b1);
    check("midrst_ovf", overflow, 1'b0);
    void'(exp_q.pop_back());
    foreach (model_acc[i]) model_acc[i] = 0;
    model_ovf = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    start_op(a_v, b_v, 1'b1, wexp);
    finish_op("rerun", wexp, 0);

    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
